// File: rtl/lock_sequencer_pkg.sv
// Shared types and default constants for the keypad lock sequencer.
package lock_pkg;

    localparam int KEY_W = 4;

    localparam int DEF_DIGITS         = 4;
    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1000;
    localparam int DEF_UNLOCK_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 500;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT
    } lock_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Keypad digit valid/ready handshake between keypad front end and sequencer.
interface lock_sequencer_if;
    import lock_pkg::*;

    logic [KEY_W-1:0] key_value;
    logic             key_valid;
    logic             key_ready;

    modport master (output key_value, output key_valid, input  key_ready);
    modport slave  (input  key_value, input  key_valid, output key_ready);
endinterface

// File: rtl/lock_sequencer_timer.sv
// Loadable down-counter shared by the OPEN, LOCKOUT and entry-timeout intervals.
module lock_timer #(
    parameter int W = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              cnt_q <= '0;
        else if (load_i)         cnt_q <= val_i;
        else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Keypad code sequencer driving the cypher-compare datapath strobes.
// Optional idle-entry abort is built when ENTRY_TIMEOUT_EN is defined.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int DIGITS         = DEF_DIGITS,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int AW = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    lock_sequencer_if.slave         key,
    input  logic [DIGITS*KEY_W-1:0] code_in,
    input  logic                    code_load,
    output logic [IW-1:0]           digit_index,
    output logic [AW-1:0]           attempts,
    output logic                    unlocked,
    output logic                    error,
    output logic                    locked_out,
    output logic                    timeout,
    output logic                    cypher_register_enable,
    output logic                    input_register_enable,
    output logic                    compare_enable,
    output logic                    output_enable
);

    localparam int CW = DIGITS * KEY_W;
    localparam int TW = $clog2(max3(LOCKOUT_CYCLES, UNLOCK_CYCLES, TIMEOUT_CYCLES)) + 1;

    lock_state_t      state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    att_q, att_d;
    logic             mism_q, mism_d;
    logic             fresh_q;
    logic             accept, last_digit, tmo;
    logic             tmr_load, tmr_done;
    logic [TW-1:0]    tmr_val;
    logic [KEY_W-1:0] cur_nib;

    // Handshake is held off while reset is asserted so every output reads 0.
    assign key.key_ready = reset && ((state_q == IDLE && !code_load) || state_q == ENTRY);
    assign accept        = key.key_valid && key.key_ready;
    assign last_digit    = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < DIGITS; i++)
            if (idx_q == IW'(i)) cur_nib = code_q[KEY_W*(DIGITS-1-i) +: KEY_W];
    end

`ifdef ENTRY_TIMEOUT_EN
    assign tmo = (state_q == ENTRY) && !accept && tmr_done;
`else
    assign tmo = 1'b0;
`endif

    lock_timer #(.W(TW)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            att_q   <= '0;
            mism_q  <= 1'b0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            att_q   <= att_d;
            mism_q  <= mism_d;
            fresh_q <= (state_d != state_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        att_d    = att_q;
        mism_d   = mism_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        // Digits are always collected in full; the verdict waits for CHECK.
        if (accept) begin
            mism_d = mism_q | (key.key_value != cur_nib);
            idx_d  = last_digit ? '0 : idx_q + IW'(1);
`ifdef ENTRY_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT_CYCLES);
`endif
        end

        case (state_q)
            IDLE: begin
                if (code_load)   code_d  = code_in;
                else if (accept) state_d = last_digit ? CHECK : ENTRY;
            end
            ENTRY: begin
                if (accept) begin
                    if (last_digit) state_d = CHECK;
                end else if (tmo) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    mism_d  = 1'b0;
                end
            end
            CHECK: begin
                mism_d = 1'b0;
                if (mism_q) begin
                    state_d = FAIL;
                end else begin
                    state_d  = OPEN;
                    att_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(UNLOCK_CYCLES);
                end
            end
            OPEN: if (tmr_done) state_d = IDLE;
            FAIL: begin
                if (att_q != AW'(MAX_ATTEMPTS)) att_d = att_q + AW'(1);
                if (att_d == AW'(MAX_ATTEMPTS)) begin
                    state_d  = LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LOCKOUT_CYCLES);
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    att_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        digit_index            = idx_q;
        attempts               = att_q;
        unlocked               = (state_q == OPEN);
        error                  = (state_q == FAIL);
        locked_out             = (state_q == LOCKOUT);
        timeout                = tmo;
        cypher_register_enable = reset && (state_q == IDLE) && code_load;
        input_register_enable  = accept;
        compare_enable         = (state_q == CHECK);
        output_enable          = (state_q == OPEN) && fresh_q;
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed table-driven bench for lock_sequencer with hand-written lockout/reset/timeout sequences.
module tb_lock_sequencer;
    import lock_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] code_in = '0;
    logic        code_load = 1'b0;
    logic [1:0]  digit_index, attempts;
    logic        unlocked, error, locked_out, timeout;
    logic        cypher_register_enable, input_register_enable, compare_enable, output_enable;

    lock_sequencer_if kif();

    always #5 clock = ~clock;

    lock_sequencer dut (
        .clock                  (clock),
        .reset                  (reset),
        .key                    (kif),
        .code_in                (code_in),
        .code_load              (code_load),
        .digit_index            (digit_index),
        .attempts               (attempts),
        .unlocked               (unlocked),
        .error                  (error),
        .locked_out             (locked_out),
        .timeout                (timeout),
        .cypher_register_enable (cypher_register_enable),
        .input_register_enable  (input_register_enable),
        .compare_enable         (compare_enable),
        .output_enable          (output_enable)
    );

    typedef struct packed {
        logic rdy, ire, cre, ce, oe, unl, err, lo, tmo;
        logic [1:0] idx, att;
    } obs_t;

    typedef struct {
        logic        load;
        logic [15:0] code;
        logic        kv;
        logic [3:0]  key;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t observe();
        obs_t o;
        o.rdy = kif.key_ready;          o.ire = input_register_enable;
        o.cre = cypher_register_enable; o.ce  = compare_enable;
        o.oe  = output_enable;          o.unl = unlocked;
        o.err = error;                  o.lo  = locked_out;
        o.tmo = timeout;                o.idx = digit_index;
        o.att = attempts;
        return o;
    endfunction

    function automatic obs_t E(input logic rdy, ire, cre, ce, oe, unl, err, lo,
                               input int idx, input int att);
        obs_t o;
        o.rdy = rdy; o.ire = ire; o.cre = cre; o.ce = ce; o.oe = oe;
        o.unl = unl; o.err = err; o.lo = lo;  o.tmo = 1'b0;
        o.idx = 2'(idx); o.att = 2'(att);
        return o;
    endfunction

    task automatic addv(input logic load, input logic [15:0] code, input logic kv,
                        input logic [3:0] key, input obs_t e);
        vec_t v;
        v.load = load; v.code = code; v.kv = kv; v.key = key; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vecs(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            code_load     = vecs[i].load;
            code_in       = vecs[i].code;
            kif.key_valid = vecs[i].kv;
            kif.key_value = vecs[i].key;
            #3;
            check($sformatf("vec%0d", i), 32'(observe()), 32'(vecs[i].exp));
            tick();
        end
        code_load     = 1'b0;
        kif.key_valid = 1'b0;
    endtask

    // Drives four digits back-to-back; valid stays high afterwards when hold is set.
    task automatic enter(input logic [15:0] c, input logic hold);
        for (int d = 3; d >= 0; d--) begin
            kif.key_valid = 1'b1;
            kif.key_value = c[4*d +: 4];
            tick();
        end
        kif.key_valid = hold;
        kif.key_value = 4'h3;
    endtask

    // Measures how long unlocked stays high, starting from the first OPEN cycle sampled already.
    task automatic drain_open(input string tag);
        int  n;
        bit  oe_extra;
        n = 1;
        oe_extra = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #3;
            if (!unlocked) break;
            n++;
            if (output_enable) oe_extra = 1'b1;
            tick();
        end
        check({tag, "_unlock_len"}, n, 16);
        check({tag, "_oe_single"}, int'(oe_extra), 0);
        check({tag, "_att_after_open"}, int'(attempts), 0);
        tick();
    endtask

    initial begin
        int errs, errk, lo_n, att_lo;
        bit bad_rdy;

        kif.key_valid = 1'b0;
        kif.key_value = '0;

        // A: load with simultaneous digit, then correct entry 3,A,7,C
        addv(1, 16'h3A7C, 1, 4'h5, E(0,0,1,0,0,0,0,0, 0,0));
        addv(0, 16'h0000, 0, 4'h0, E(1,0,0,0,0,0,0,0, 0,0));
        addv(0, 16'h0000, 1, 4'h3, E(1,1,0,0,0,0,0,0, 0,0));
        addv(0, 16'h0000, 1, 4'hA, E(1,1,0,0,0,0,0,0, 1,0));
        addv(0, 16'h0000, 1, 4'h7, E(1,1,0,0,0,0,0,0, 2,0));
        addv(0, 16'h0000, 1, 4'hC, E(1,1,0,0,0,0,0,0, 3,0));
        addv(0, 16'h0000, 0, 4'h0, E(0,0,0,1,0,0,0,0, 0,0));
        addv(0, 16'h0000, 0, 4'h0, E(0,0,0,0,1,1,0,0, 0,0));
        // B: wrong last digit 3,A,7,D
        addv(0, 16'h0000, 1, 4'h3, E(1,1,0,0,0,0,0,0, 0,0));
        addv(0, 16'h0000, 1, 4'hA, E(1,1,0,0,0,0,0,0, 1,0));
        addv(0, 16'h0000, 1, 4'h7, E(1,1,0,0,0,0,0,0, 2,0));
        addv(0, 16'h0000, 1, 4'hD, E(1,1,0,0,0,0,0,0, 3,0));
        addv(0, 16'h0000, 0, 4'h0, E(0,0,0,1,0,0,0,0, 0,0));
        addv(0, 16'h0000, 0, 4'h0, E(0,0,0,0,0,0,1,0, 0,0));
        addv(0, 16'h0000, 0, 4'h0, E(1,0,0,0,0,0,0,0, 0,1));
        // C: after reset the stored code is zero
        addv(0, 16'h0000, 1, 4'h0, E(1,1,0,0,0,0,0,0, 0,0));
        addv(0, 16'h0000, 1, 4'h0, E(1,1,0,0,0,0,0,0, 1,0));
        addv(0, 16'h0000, 1, 4'h0, E(1,1,0,0,0,0,0,0, 2,0));
        addv(0, 16'h0000, 1, 4'h0, E(1,1,0,0,0,0,0,0, 3,0));
        addv(0, 16'h0000, 0, 4'h0, E(0,0,0,1,0,0,0,0, 0,0));
        addv(0, 16'h0000, 0, 4'h0, E(0,0,0,0,1,1,0,0, 0,0));

        repeat (2) @(posedge clock);
        #1;
        kif.key_valid = 1'b1;
        #3;
        check("reset_outs", 32'(observe()), 0);
        kif.key_valid = 1'b0;
        reset = 1'b1;
        tick();

        run_vecs(0, 7);
        drain_open("A");
        run_vecs(8, 14);

        // Second wrong entry: single error pulse on the cycle after CHECK
        enter(16'h1111, 1'b0);
        errs = 0; errk = -1;
        for (int k = 0; k < 4; k++) begin
            #3;
            if (error) begin errs++; errk = k; end
            tick();
        end
        check("err2_count", errs, 1);
        check("err2_cycle", errk, 1);
        check("err2_attempts", int'(attempts), 2);

        // Third wrong entry with valid held high throughout the lockout
        enter(16'h2222, 1'b1);
        #3; check("err3_check", int'(compare_enable), 1);
        tick();
        #3; check("err3_error", int'(error), 1);
        tick();
        lo_n = 0; att_lo = -1; bad_rdy = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            #3;
            if (!locked_out) break;
            lo_n++;
            if (lo_n == 1) att_lo = int'(attempts);
            if (kif.key_ready || input_register_enable) bad_rdy = 1'b1;
            tick();
        end
        kif.key_valid = 1'b0;
        #1;
        check("lockout_len", lo_n, 1000);
        check("lockout_att", att_lo, 3);
        check("lockout_no_accept", int'(bad_rdy), 0);
        check("post_lockout_att", int'(attempts), 0);
        check("post_lockout_rdy", int'(kif.key_ready), 1);
        tick();

        // Reset mid-entry after two correct digits
        kif.key_valid = 1'b1; kif.key_value = 4'h3; tick();
        kif.key_value = 4'hA; tick();
        kif.key_valid = 1'b0;
        #3; check("mid_idx", int'(digit_index), 2);
        reset = 1'b0;
        #1; check("reset_mid_outs", 32'(observe()), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        run_vecs(15, 20);
        drain_open("C");

`ifdef ENTRY_TIMEOUT_EN
        begin
            int n, att_b;
            att_b = int'(attempts);
            kif.key_valid = 1'b1; kif.key_value = 4'h5; tick();
            kif.key_valid = 1'b0;
            n = 0;
            for (int k = 0; k < 1000; k++) begin
                #3;
                n++;
                if (timeout) break;
                tick();
            end
            check("timeout_len", n, 500);
            tick();
            #3;
            check("timeout_idx", int'(digit_index), 0);
            check("timeout_att", int'(attempts), att_b);
            check("timeout_rdy", int'(kif.key_ready), 1);
            check("timeout_single", int'(timeout), 0);
            tick();
            enter(16'h0000, 1'b0);
            tick();
            #3; check("timeout_then_open", int'(unlocked), 1);
            tick();
            drain_open("T");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
